// File: rtl/mor1kx_wb_ibus_dbus_arbiter.sv
// Two-master (instruction/data) to one-master Wishbone B3 arbiter.
// Grants are held for the whole CYC; an optional watchdog ends hung cycles with an error.
module mor1kx_wb_ibus_dbus_arbiter #(
   parameter string OPTION_ARB_MODE      = "ROUND_ROBIN",
   parameter int    OPTION_TIMEOUT_WIDTH = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] iwbs_adr_i,
   input  logic [31:0] iwbs_dat_i,
   input  logic        iwbs_stb_i,
   input  logic        iwbs_cyc_i,
   input  logic        iwbs_we_i,
   input  logic [3:0]  iwbs_sel_i,
   input  logic [2:0]  iwbs_cti_i,
   input  logic [1:0]  iwbs_bte_i,
   output logic        iwbs_ack_o,
   output logic        iwbs_err_o,
   output logic        iwbs_rty_o,
   output logic [31:0] iwbs_dat_o,
   input  logic [31:0] dwbs_adr_i,
   input  logic [31:0] dwbs_dat_i,
   input  logic        dwbs_stb_i,
   input  logic        dwbs_cyc_i,
   input  logic        dwbs_we_i,
   input  logic [3:0]  dwbs_sel_i,
   input  logic [2:0]  dwbs_cti_i,
   input  logic [1:0]  dwbs_bte_i,
   output logic        dwbs_ack_o,
   output logic        dwbs_err_o,
   output logic        dwbs_rty_o,
   output logic [31:0] dwbs_dat_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic        wbm_stb_o,
   output logic        wbm_cyc_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,
   input  logic [31:0] wbm_dat_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   localparam bit DBUS_PRIO = (OPTION_ARB_MODE == "DBUS_PRIORITY");

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

   state_t state_reg, state_next;
   logic   last_grant_reg, last_grant_next;   // 0 = instruction, 1 = data
   logic   gnt_i, gnt_d;
   logic   req_stb, resp, fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         IDLE: begin
            if (iwbs_cyc_i && dwbs_cyc_i)
               state_next = (DBUS_PRIO || !last_grant_reg) ? GRANT_D : GRANT_I;
            else if (iwbs_cyc_i)
               state_next = GRANT_I;
            else if (dwbs_cyc_i)
               state_next = GRANT_D;
         end
         // On release, hand straight over to a waiting master to avoid an idle bubble.
         GRANT_I: begin
            if (!iwbs_cyc_i) begin
               last_grant_next = 1'b0;
               state_next      = dwbs_cyc_i ? GRANT_D : IDLE;
            end
         end
         GRANT_D: begin
            if (!dwbs_cyc_i) begin
               last_grant_next = 1'b1;
               state_next      = iwbs_cyc_i ? GRANT_I : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Gating with rst drops any response still in flight while reset is applied.
   assign gnt_i   = (state_reg == GRANT_I) && !rst;
   assign gnt_d   = (state_reg == GRANT_D) && !rst;
   assign req_stb = (gnt_i && iwbs_stb_i) || (gnt_d && dwbs_stb_i);
   assign resp    = wbm_ack_i || wbm_err_i || wbm_rty_i;

   always_comb begin
      wbm_adr_o = '0;
      wbm_dat_o = '0;
      wbm_cyc_o = 1'b0;
      wbm_we_o  = 1'b0;
      wbm_sel_o = '0;
      wbm_cti_o = '0;
      wbm_bte_o = '0;
      if (gnt_i) begin
         wbm_adr_o = iwbs_adr_i;
         wbm_dat_o = iwbs_dat_i;
         wbm_cyc_o = iwbs_cyc_i;
         wbm_we_o  = iwbs_we_i;
         wbm_sel_o = iwbs_sel_i;
         wbm_cti_o = iwbs_cti_i;
         wbm_bte_o = iwbs_bte_i;
      end else if (gnt_d) begin
         wbm_adr_o = dwbs_adr_i;
         wbm_dat_o = dwbs_dat_i;
         wbm_cyc_o = dwbs_cyc_i;
         wbm_we_o  = dwbs_we_i;
         wbm_sel_o = dwbs_sel_i;
         wbm_cti_o = dwbs_cti_i;
         wbm_bte_o = dwbs_bte_i;
      end
   end

   assign wbm_stb_o  = req_stb && !fire;
   assign iwbs_ack_o = gnt_i && wbm_ack_i;
   assign iwbs_err_o = gnt_i && (wbm_err_i || fire);
   assign iwbs_rty_o = gnt_i && wbm_rty_i;
   assign iwbs_dat_o = gnt_i ? wbm_dat_i : 32'h0;
   assign dwbs_ack_o = gnt_d && wbm_ack_i;
   assign dwbs_err_o = gnt_d && (wbm_err_i || fire);
   assign dwbs_rty_o = gnt_d && wbm_rty_i;
   assign dwbs_dat_o = gnt_d ? wbm_dat_i : 32'h0;
   assign grant_o    = {gnt_d, gnt_i};
   assign timeout_o  = fire;

   generate
      if (OPTION_TIMEOUT_WIDTH > 0) begin : g_wdog
         logic [OPTION_TIMEOUT_WIDTH-1:0] wd_cnt_reg;
         logic                            stalled;

         // A real response in the same cycle wins over the timeout.
         assign stalled = req_stb && !resp;
         assign fire    = stalled && (&wd_cnt_reg);

         always_ff @(posedge clk) begin
            if (rst)
               wd_cnt_reg <= '0;
            else if (state_reg == IDLE || state_next != state_reg || resp || fire)
               wd_cnt_reg <= '0;
            else if (stalled)
               wd_cnt_reg <= wd_cnt_reg + 1'b1;
         end
      end else begin : g_no_wdog
         assign fire = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_mor1kx_wb_ibus_dbus_arbiter.sv
// Bench for the ibus/dbus arbiter: a round-robin instance with a 4-bit watchdog and a
// dbus-priority instance without one share all stimulus; acks are checked via a scoreboard.
module tb_mor1kx_wb_ibus_dbus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] i_adr, i_dat, d_adr, d_dat, wdat;
   logic        i_stb, i_cyc, i_we, d_stb, d_cyc, d_we, wack, werr, wrty;
   logic [3:0]  i_sel, d_sel;
   logic [2:0]  i_cti, d_cti;
   logic [1:0]  i_bte, d_bte;

   logic        rr_iack, rr_ierr, rr_irty, rr_dack, rr_derr, rr_drty;
   logic [31:0] rr_idat, rr_ddat, rr_adr, rr_wdat;
   logic        rr_stb, rr_cyc, rr_we, rr_to;
   logic [3:0]  rr_sel;
   logic [2:0]  rr_cti;
   logic [1:0]  rr_bte, rr_gnt;

   logic        dp_iack, dp_ierr, dp_irty, dp_dack, dp_derr, dp_drty;
   logic [31:0] dp_idat, dp_ddat, dp_adr, dp_wdat;
   logic        dp_stb, dp_cyc, dp_we, dp_to;
   logic [3:0]  dp_sel;
   logic [2:0]  dp_cti;
   logic [1:0]  dp_bte, dp_gnt;

   mor1kx_wb_ibus_dbus_arbiter #(.OPTION_ARB_MODE("ROUND_ROBIN"), .OPTION_TIMEOUT_WIDTH(4)) dut_rr (
      .clk(clk), .rst(rst),
      .iwbs_adr_i(i_adr), .iwbs_dat_i(i_dat), .iwbs_stb_i(i_stb), .iwbs_cyc_i(i_cyc),
      .iwbs_we_i(i_we), .iwbs_sel_i(i_sel), .iwbs_cti_i(i_cti), .iwbs_bte_i(i_bte),
      .iwbs_ack_o(rr_iack), .iwbs_err_o(rr_ierr), .iwbs_rty_o(rr_irty), .iwbs_dat_o(rr_idat),
      .dwbs_adr_i(d_adr), .dwbs_dat_i(d_dat), .dwbs_stb_i(d_stb), .dwbs_cyc_i(d_cyc),
      .dwbs_we_i(d_we), .dwbs_sel_i(d_sel), .dwbs_cti_i(d_cti), .dwbs_bte_i(d_bte),
      .dwbs_ack_o(rr_dack), .dwbs_err_o(rr_derr), .dwbs_rty_o(rr_drty), .dwbs_dat_o(rr_ddat),
      .wbm_adr_o(rr_adr), .wbm_dat_o(rr_wdat), .wbm_stb_o(rr_stb), .wbm_cyc_o(rr_cyc),
      .wbm_we_o(rr_we), .wbm_sel_o(rr_sel), .wbm_cti_o(rr_cti), .wbm_bte_o(rr_bte),
      .wbm_ack_i(wack), .wbm_err_i(werr), .wbm_rty_i(wrty), .wbm_dat_i(wdat),
      .grant_o(rr_gnt), .timeout_o(rr_to));

   mor1kx_wb_ibus_dbus_arbiter #(.OPTION_ARB_MODE("DBUS_PRIORITY"), .OPTION_TIMEOUT_WIDTH(0)) dut_dp (
      .clk(clk), .rst(rst),
      .iwbs_adr_i(i_adr), .iwbs_dat_i(i_dat), .iwbs_stb_i(i_stb), .iwbs_cyc_i(i_cyc),
      .iwbs_we_i(i_we), .iwbs_sel_i(i_sel), .iwbs_cti_i(i_cti), .iwbs_bte_i(i_bte),
      .iwbs_ack_o(dp_iack), .iwbs_err_o(dp_ierr), .iwbs_rty_o(dp_irty), .iwbs_dat_o(dp_idat),
      .dwbs_adr_i(d_adr), .dwbs_dat_i(d_dat), .dwbs_stb_i(d_stb), .dwbs_cyc_i(d_cyc),
      .dwbs_we_i(d_we), .dwbs_sel_i(d_sel), .dwbs_cti_i(d_cti), .dwbs_bte_i(d_bte),
      .dwbs_ack_o(dp_dack), .dwbs_err_o(dp_derr), .dwbs_rty_o(dp_drty), .dwbs_dat_o(dp_ddat),
      .wbm_adr_o(dp_adr), .wbm_dat_o(dp_wdat), .wbm_stb_o(dp_stb), .wbm_cyc_o(dp_cyc),
      .wbm_we_o(dp_we), .wbm_sel_o(dp_sel), .wbm_cti_o(dp_cti), .wbm_bte_o(dp_bte),
      .wbm_ack_i(wack), .wbm_err_i(werr), .wbm_rty_i(wrty), .wbm_dat_i(wdat),
      .grant_o(dp_gnt), .timeout_o(dp_to));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard of acks the round-robin instance must deliver: master (0=I, 1=D) and data.
   typedef struct {
      logic        m;
      logic [31:0] d;
   } sb_t;
   sb_t sbq[$];
   sb_t mon_e;

   always @(negedge clk) begin
      if (rr_iack || rr_dack) begin
         if (sbq.size() == 0) begin
            chk("unexpected_ack", {30'b0, rr_dack, rr_iack}, 32'h0);
         end else begin
            mon_e = sbq.pop_front();
            chk("ack_master", {30'b0, rr_dack, rr_iack}, mon_e.m ? 32'h2 : 32'h1);
            chk("ack_data", rr_dack ? rr_ddat : rr_idat, mon_e.d);
            $display("[TB] ack to %s data %h", mon_e.m ? "D" : "I", mon_e.d);
         end
      end
   end

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic clr;
      i_adr = 0; i_dat = 0; i_stb = 0; i_cyc = 0; i_we = 0; i_sel = 4'hf; i_cti = 0; i_bte = 0;
      d_adr = 0; d_dat = 0; d_stb = 0; d_cyc = 0; d_we = 0; d_sel = 4'hf; d_cti = 0; d_bte = 0;
      wack = 0; werr = 0; wrty = 0; wdat = 0;
   endtask

   task automatic give_ack(input logic m, input logic [31:0] d);
      wack = 1'b1;
      wdat = d;
      sbq.push_back('{m: m, d: d});
   endtask

   typedef struct {
      logic       ic, dc, ak;
      logic [1:0] g_rr, g_dp;
      logic       cyc_rr;
   } vec_t;
   vec_t tv[16];

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout: got running, expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      // Tie-break table: one row per cycle, both masters strobe whenever they hold cyc.
      tv[0]  = '{1,1,0, 2'b00, 2'b00, 0};
      tv[1]  = '{1,1,1, 2'b10, 2'b10, 1};
      tv[2]  = '{1,0,0, 2'b10, 2'b10, 0};
      tv[3]  = '{1,1,1, 2'b01, 2'b01, 1};
      tv[4]  = '{0,1,0, 2'b01, 2'b01, 0};
      tv[5]  = '{1,1,1, 2'b10, 2'b10, 1};
      tv[6]  = '{0,0,0, 2'b10, 2'b10, 0};
      tv[7]  = '{1,1,0, 2'b00, 2'b00, 0};
      tv[8]  = '{1,1,1, 2'b01, 2'b10, 1};
      tv[9]  = '{0,0,0, 2'b01, 2'b10, 0};
      tv[10] = '{1,1,0, 2'b00, 2'b00, 0};
      tv[11] = '{1,1,1, 2'b10, 2'b10, 1};
      tv[12] = '{0,0,0, 2'b10, 2'b10, 0};
      tv[13] = '{1,0,0, 2'b00, 2'b00, 0};
      tv[14] = '{0,0,0, 2'b01, 2'b01, 0};
      tv[15] = '{0,0,0, 2'b00, 2'b00, 0};

      clr();
      rst = 1'b1;
      repeat (3) nxt();
      rst = 1'b0;
      smp();
      chk("reset_grant_rr", {30'b0, rr_gnt}, 0);
      chk("reset_grant_dp", {30'b0, dp_gnt}, 0);
      chk("reset_wbm_cyc", {31'b0, rr_cyc}, 0);
      chk("reset_acks", {28'b0, rr_iack, rr_dack, dp_iack, dp_dack}, 0);
      chk("reset_timeout", {31'b0, rr_to}, 0);

      // Instruction-only read with a slave that acks two cycles after the bus cycle opens.
      nxt(); i_cyc = 1; i_stb = 1; i_adr = 32'h100;
      smp(); chk("ionly_c0_cyc", {31'b0, rr_cyc}, 0);
      nxt();
      smp(); chk("ionly_c1_cyc", {31'b0, rr_cyc}, 1);
      chk("ionly_c1_adr", rr_adr, 32'h100);
      chk("ionly_c1_grant", {30'b0, rr_gnt}, 2'b01);
      nxt();
      smp(); chk("ionly_c2_stb", {31'b0, rr_stb}, 1);
      nxt(); give_ack(1'b0, 32'hDEADBEEF);
      smp(); chk("ionly_dack", {31'b0, rr_dack}, 0);
      nxt(); wack = 0; i_cyc = 0; i_stb = 0;
      smp(); chk("ionly_release_cyc", {31'b0, rr_cyc}, 0);
      nxt();
      smp(); chk("ionly_idle_grant", {30'b0, rr_gnt}, 0);

      nxt(); rst = 1'b1;
      nxt(); rst = 1'b0;
      for (int r = 0; r < 16; r++) begin
         nxt();
         i_cyc = tv[r].ic; i_stb = tv[r].ic; i_adr = 32'h400 + r;
         d_cyc = tv[r].dc; d_stb = tv[r].dc; d_adr = 32'h800 + r;
         if (tv[r].ak) give_ack(tv[r].g_rr[1], 32'hA000_0000 | r);
         else wack = 0;
         smp();
         chk($sformatf("tie_row%0d_grant_rr", r), {30'b0, rr_gnt}, {30'b0, tv[r].g_rr});
         chk($sformatf("tie_row%0d_grant_dp", r), {30'b0, dp_gnt}, {30'b0, tv[r].g_dp});
         chk($sformatf("tie_row%0d_wbm_cyc", r), {31'b0, rr_cyc}, {31'b0, tv[r].cyc_rr});
      end

      // Eight-beat incrementing burst from ibus, dbus starts requesting at beat 2.
      nxt(); clr(); i_cyc = 1; i_stb = 1; i_cti = 3'b010; i_adr = 32'h200;
      smp(); chk("burst_start_grant", {30'b0, rr_gnt}, 0);
      for (int k = 0; k < 8; k++) begin
         nxt();
         i_cti = (k == 7) ? 3'b111 : 3'b010;
         i_adr = 32'h200 + 4 * k;
         d_cyc = (k >= 2); d_stb = (k >= 2); d_adr = 32'h900;
         give_ack(1'b0, 32'h1000 + k);
         smp();
         chk($sformatf("burst_beat%0d_grant", k), {30'b0, rr_gnt}, 2'b01);
         chk($sformatf("burst_beat%0d_cti", k), {29'b0, rr_cti}, (k == 7) ? 32'h7 : 32'h2);
      end
      nxt(); wack = 0; i_cyc = 0; i_stb = 0; i_cti = 0;
      smp(); chk("burst_end_grant", {30'b0, rr_gnt}, 2'b01);
      chk("burst_end_cyc", {31'b0, rr_cyc}, 0);
      nxt();
      smp(); chk("burst_handover_grant", {30'b0, rr_gnt}, 2'b10);
      chk("burst_handover_adr", rr_adr, 32'h900);
      nxt(); d_cyc = 0; d_stb = 0;
      nxt();
      smp(); chk("burst_idle_grant", {30'b0, rr_gnt}, 0);

      // Watchdog: dbus access to a slave that never answers.
      nxt(); d_cyc = 1; d_stb = 1; d_adr = 32'h300;
      smp();
      for (int w = 1; w <= 15; w++) begin
         nxt(); smp();
         chk($sformatf("wdog_w%0d_timeout", w), {31'b0, rr_to}, 0);
      end
      nxt(); smp();
      chk("wdog_fire_timeout", {31'b0, rr_to}, 1);
      chk("wdog_fire_derr", {31'b0, rr_derr}, 1);
      chk("wdog_fire_ierr", {31'b0, rr_ierr}, 0);
      chk("wdog_fire_stb", {31'b0, rr_stb}, 0);
      chk("wdog_disabled_timeout", {31'b0, dp_to}, 0);
      chk("wdog_disabled_derr", {31'b0, dp_derr}, 0);
      nxt(); smp();
      chk("wdog_after_timeout", {31'b0, rr_to}, 0);
      chk("wdog_after_derr", {31'b0, rr_derr}, 0);
      chk("wdog_after_stb", {31'b0, rr_stb}, 1);
      for (int w = 18; w <= 31; w++) begin
         nxt(); smp();
         chk($sformatf("wdog_w%0d_timeout", w), {31'b0, rr_to}, 0);
      end
      nxt(); smp();
      chk("wdog_refire_timeout", {31'b0, rr_to}, 1);
      for (int w = 33; w <= 47; w++) begin
         nxt(); smp();
      end
      nxt(); give_ack(1'b1, 32'h5A5A_0048);
      smp(); chk("wdog_ack_wins", {31'b0, rr_to}, 0);
      nxt(); wack = 0; werr = 1;
      smp(); chk("err_pass_derr", {31'b0, rr_derr}, 1);
      chk("err_pass_ierr", {31'b0, rr_ierr}, 0);
      nxt(); werr = 0; d_cyc = 0; d_stb = 0;
      smp(); chk("err_grant_held", {30'b0, rr_gnt}, 2'b10);
      nxt();
      smp(); chk("err_idle_grant", {30'b0, rr_gnt}, 0);

      // Reset while a dbus cycle with a pending ack is in progress.
      nxt(); d_cyc = 1; d_stb = 1; d_adr = 32'h700;
      smp();
      nxt();
      smp(); chk("rstmid_grant_d", {30'b0, rr_gnt}, 2'b10);
      nxt(); rst = 1'b1; wack = 1; wdat = 32'h0BAD_0BAD;
      smp(); chk("rstmid_during_grant", {30'b0, rr_gnt}, 0);
      chk("rstmid_during_dack", {31'b0, rr_dack}, 0);
      nxt(); rst = 1'b0;
      smp(); chk("rstmid_after_grant", {30'b0, rr_gnt}, 0);
      chk("rstmid_after_cyc", {31'b0, rr_cyc}, 0);
      chk("rstmid_after_acks", {30'b0, rr_iack, rr_dack}, 0);
      nxt(); clr();
      repeat (3) nxt();
      smp(); chk("scoreboard_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
